// File: rtl/calc_operand_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_operand_seq_pkg
// Description : Shared definitions for the calculator operand sequencer:
//               the operand width and the 2-bit FSM state encoding that is
//               also exported on the status LEDs.
// Revision    : 1.0 - initial release
// ============================================================================
package calc_operand_seq_pkg;

    localparam int c_OPERAND_W = 4;

    // Encoding is visible externally on o_state, so the values are fixed.
    typedef enum logic [1:0] {
        GET_A = 2'd0,
        GET_B = 2'd1,
        CALC  = 2'd2,
        SHOW  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/calc_operand_seq_btn_edge.sv
`default_nettype none
// ============================================================================
// Module      : calc_operand_seq_btn_edge
// Description : Rising-edge detector for an already synchronized button level.
//               Produces a single-cycle pulse when the level goes 0 -> 1.
//               The history register resets to 1 so a button that is held
//               while reset is released does not produce a spurious event.
// Ports       : i_clk   - system clock
//               i_reset - asynchronous active-high reset
//               i_btn   - button level
//               o_event - one-cycle pulse on the rising edge of i_btn
// Revision    : 1.0 - initial release
// ============================================================================
module calc_operand_seq_btn_edge (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_event
);

    logic r_prev;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= i_btn;
        end
    end

    assign o_event = i_btn & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/calc_operand_seq.sv
`default_nettype none
// ============================================================================
// Module      : calc_operand_seq
// Description : Operand-entry sequencer for the 4-bit calculator. Captures
//               operand A then operand B from the switches on successive
//               ENTER events, drives the external ripple adder from
//               registers and, one cycle after B is captured, latches the
//               adder's {carry, sum} into a 5-bit result with a valid flag.
//               CLEAR returns everything to the idle state and wins over a
//               simultaneous ENTER.
// Config      : CALC_SUB_EN - when defined, adds i_op_sub and a two's-
//               complement subtract mode (o_add_b = ~B, o_add_c = 1).
// Ports       : i_clk, i_reset       - clock, async active-high reset
//               i_sw                 - operand switches
//               i_btn_enter/clear    - synchronized button levels
//               i_op_sub             - subtract select (CALC_SUB_EN only)
//               o_add_a/b/c          - adder operands and carry-in
//               i_add_sum/i_add_c    - adder sum and carry-out
//               o_result/_valid      - last completed result and its flag
//               o_state              - current FSM state
// Revision    : 1.0 - initial release
// ============================================================================
module calc_operand_seq
    import calc_operand_seq_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [c_OPERAND_W-1:0] i_sw,
    input  logic                   i_btn_enter,
    input  logic                   i_btn_clear,
`ifdef CALC_SUB_EN
    input  logic                   i_op_sub,
`endif
    output logic [c_OPERAND_W-1:0] o_add_a,
    output logic [c_OPERAND_W-1:0] o_add_b,
    output logic                   o_add_c,
    input  logic [c_OPERAND_W-1:0] i_add_sum,
    input  logic                   i_add_c,
    output logic [c_OPERAND_W:0]   o_result,
    output logic                   o_result_valid,
    output logic [1:0]             o_state
);

    logic w_enter_evt;
    logic w_clear_evt;

    calc_operand_seq_btn_edge u_enter_edge (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_btn   (i_btn_enter),
        .o_event (w_enter_evt)
    );

    calc_operand_seq_btn_edge u_clear_edge (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_btn   (i_btn_clear),
        .o_event (w_clear_evt)
    );

    state_t                 r_state, w_state_nxt;
    logic [c_OPERAND_W-1:0] r_a, w_a_nxt;
    logic [c_OPERAND_W-1:0] r_b, w_b_nxt;
    logic [c_OPERAND_W:0]   r_result, w_result_nxt;
    logic                   r_valid, w_valid_nxt;
`ifdef CALC_SUB_EN
    logic                   r_op, w_op_nxt;
`endif

    // Register process: FSM state plus the datapath registers it controls.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= GET_A;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
`ifdef CALC_SUB_EN
            r_op     <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_result <= w_result_nxt;
            r_valid  <= w_valid_nxt;
`ifdef CALC_SUB_EN
            r_op     <= w_op_nxt;
`endif
        end
    end

    // Next-state / next-data process. CLEAR is checked first so that it
    // overrides an ENTER occurring in the same cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_result_nxt = r_result;
        w_valid_nxt  = r_valid;
`ifdef CALC_SUB_EN
        w_op_nxt     = r_op;
`endif
        if (w_clear_evt) begin
            w_state_nxt  = GET_A;
            w_a_nxt      = '0;
            w_b_nxt      = '0;
            w_result_nxt = '0;
            w_valid_nxt  = 1'b0;
`ifdef CALC_SUB_EN
            w_op_nxt     = 1'b0;
`endif
        end else begin
            case (r_state)
                GET_A: begin
                    if (w_enter_evt) begin
                        w_a_nxt     = i_sw;
                        w_state_nxt = GET_B;
                    end
                end
                GET_B: begin
                    if (w_enter_evt) begin
                        w_b_nxt     = i_sw;
`ifdef CALC_SUB_EN
                        w_op_nxt    = i_op_sub;
`endif
                        w_state_nxt = CALC;
                    end
                end
                CALC: begin
                    // Adder inputs have been stable since the B capture.
                    w_result_nxt = {i_add_c, i_add_sum};
                    w_valid_nxt  = 1'b1;
                    w_state_nxt  = SHOW;
                end
                SHOW: begin
                    // New calculation: A is taken directly from this press.
                    if (w_enter_evt) begin
                        w_a_nxt     = i_sw;
                        w_valid_nxt = 1'b0;
                        w_state_nxt = GET_B;
                    end
                end
                default: begin
                    w_state_nxt = GET_A;
                end
            endcase
        end
    end

    assign o_add_a = r_a;
`ifdef CALC_SUB_EN
    // A - B computed as A + ~B + 1; carry-out of 1 means no borrow.
    assign o_add_b = r_op ? ~r_b : r_b;
    assign o_add_c = r_op;
`else
    assign o_add_b = r_b;
    assign o_add_c = 1'b0;
`endif

    assign o_result       = r_result;
    assign o_result_valid = r_valid;
    assign o_state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_calc_operand_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_operand_seq
// Description : Self-checking bench for calc_operand_seq. A behavioural adder
//               closes the loop around the DUT; expected results are pushed
//               to a scoreboard queue when operand B is entered and popped
//               when the result becomes valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_operand_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw;
    logic       enter;
    logic       clear;
    logic       op_sub;
    logic [3:0] add_a, add_b, add_sum;
    logic       add_cin, add_cout;
    logic [4:0] result;
    logic       result_valid;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [4:0] sb[$];

    always #5 clk = ~clk;

    // External ripple adder model.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

    calc_operand_seq dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_sw           (sw),
        .i_btn_enter    (enter),
        .i_btn_clear    (clear),
`ifdef CALC_SUB_EN
        .i_op_sub       (op_sub),
`endif
        .o_add_a        (add_a),
        .o_add_b        (add_b),
        .o_add_c        (add_cin),
        .i_add_sum      (add_sum),
        .i_add_c        (add_cout),
        .o_result       (result),
        .o_result_valid (result_valid),
        .o_state        (state)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_state"}, {6'd0, state}, 8'd0);
        check({tag, "_a"}, {4'd0, add_a}, 8'd0);
        check({tag, "_b"}, {4'd0, add_b}, 8'd0);
        check({tag, "_c"}, {7'd0, add_cin}, 8'd0);
        check({tag, "_res"}, {3'd0, result}, 8'd0);
        check({tag, "_vld"}, {7'd0, result_valid}, 8'd0);
    endtask

    task automatic press(input logic [3:0] v);
        @(negedge clk);
        sw    = v;
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
    endtask

    // Full calculation starting from GET_A or SHOW.
    task automatic do_calc(input logic [3:0] a, input logic [3:0] b, input logic sub);
        logic [4:0] exp_res;
        logic [4:0] got;
        press(a);
        check("a_state", {6'd0, state}, 8'd1);
        check("a_valid_drop", {7'd0, result_valid}, 8'd0);
        op_sub = sub;
        press(b);
        if (sub) exp_res = {(a >= b), 4'(a - b)};
        else     exp_res = {1'b0, a} + {1'b0, b};
        sb.push_back(exp_res);
        check("b_state", {6'd0, state}, 8'd2);
        check("add_a", {4'd0, add_a}, {4'd0, a});
        check("add_b", {4'd0, add_b}, {4'd0, (sub ? ~b : b)});
        check("add_c", {7'd0, add_cin}, {7'd0, sub});
        check("calc_valid_low", {7'd0, result_valid}, 8'd0);
        @(posedge clk);
        #1;
        check("res_valid", {7'd0, result_valid}, 8'd1);
        check("show_state", {6'd0, state}, 8'd3);
        got = result;
        if (sb.size() > 0) check("result", {3'd0, got}, {3'd0, sb.pop_front()});
        op_sub = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sw = 4'd0; enter = 1'b0; clear = 1'b0; op_sub = 1'b0;
        #1;
        check_idle("reset");
        @(negedge clk);
        rst = 1'b0;

        // Basic add, then restart from SHOW.
        do_calc(4'h9, 4'h8, 1'b0);
        press(4'hF);
        check("restart_a", {4'd0, add_a}, 8'h0F);
        check("restart_vld", {7'd0, result_valid}, 8'd0);
        check("restart_state", {6'd0, state}, 8'd1);
        check("restart_res_hold", {3'd0, result}, 8'h11);
        op_sub = 1'b0;
        press(4'h7);
        sb.push_back(5'h16);
        @(posedge clk); #1;
        check("f_plus_7_vld", {7'd0, result_valid}, 8'd1);
        check("f_plus_7", {3'd0, result}, {3'd0, sb.pop_front()});

        // Largest operands.
        do_calc(4'hF, 4'hF, 1'b0);

        // CLEAR and ENTER together in GET_B: CLEAR wins.
        press(4'h4);
        @(negedge clk);
        sw = 4'hA; enter = 1'b1; clear = 1'b1;
        @(negedge clk);
        enter = 1'b0; clear = 1'b0;
        check_idle("collision");

        // Held ENTER for 10 cycles gives a single event.
        @(negedge clk);
        sw = 4'h3; enter = 1'b1;
        repeat (10) @(negedge clk);
        enter = 1'b0;
        check("held_state", {6'd0, state}, 8'd1);
        check("held_a", {4'd0, add_a}, 8'h03);
        check("held_b", {4'd0, add_b}, 8'h00);

        // CLEAR in SHOW wipes the result.
        press(4'h1);
        @(posedge clk); #1;
        check("pre_clear_res", {3'd0, result}, 8'h04);
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        check_idle("clear_show");

        // Asynchronous reset mid-cycle while in CALC: no capture.
        press(4'h6);
        press(4'h5);
        check("pre_rst_state", {6'd0, state}, 8'd2);
        #2 rst = 1'b1;
        #1;
        check_idle("async_rst");
        @(negedge clk);
        // Button held through reset release must not register.
        enter = 1'b1; sw = 4'h9;
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        enter = 1'b0;
        check_idle("held_at_release");

`ifdef CALC_SUB_EN
        do_calc(4'h5, 4'h3, 1'b1);
        check("sub_5_3", {3'd0, result}, 8'h12);
        do_calc(4'h3, 4'h5, 1'b1);
        check("sub_3_5", {3'd0, result}, 8'h0E);
`endif

        check("sb_empty", 8'(sb.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
